// File: rtl/edge_skew_feeder.sv
// Diagonal-skew operand feeder for the west/north edges of the PE array.
// Optional bubble counter enabled by defining FEEDER_BUBBLE_CNT_EN.
module edge_skew_feeder #(
    parameter  int ROWS     = 4,
    parameter  int COLS     = 4,
    parameter  int NUM_BITS = 8,
    parameter  int K_MAX    = 16,
    localparam int KW       = $clog2(K_MAX + 1)
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               start_i,
    input  logic [KW-1:0]                      k_i,
    output logic                               busy_o,
    output logic                               done_o,
    input  logic                               in_valid_i,
    output logic                               in_ready_o,
    input  logic [ROWS-1:0][NUM_BITS-1:0]      a_i,
    input  logic [COLS-1:0][NUM_BITS-1:0]      b_i,
    output logic [ROWS-1:0][NUM_BITS-1:0]      left_o,
    output logic [ROWS-1:0]                    left_valid_o,
    output logic [COLS-1:0][NUM_BITS-1:0]      top_o,
    output logic [COLS-1:0]                    top_valid_o
`ifdef FEEDER_BUBBLE_CNT_EN
    ,
    output logic [15:0]                        bubble_cnt_o
`endif
);

    localparam int D  = (ROWS > COLS) ? ROWS : COLS;
    localparam int DW = $clog2(D + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_next;
    logic [KW-1:0]   r_beats;
    logic [DW-1:0]   r_drain;
    logic [KW-1:0]   w_k_clamp;
    logic            w_accept;
    logic            w_start_acc;

    assign w_k_clamp   = (k_i > KW'(K_MAX)) ? KW'(K_MAX) : k_i;
    assign w_accept    = in_ready_o & in_valid_i;
    assign w_start_acc = (r_state == S_IDLE) & start_i;

    always_comb begin
        w_next     = r_state;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        in_ready_o = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start_i)
                    w_next = (k_i == '0) ? S_DONE : S_STREAM;
            end
            S_STREAM: begin
                busy_o     = 1'b1;
                in_ready_o = 1'b1;
                if (in_valid_i && r_beats == KW'(1))
                    w_next = S_DRAIN;
            end
            S_DRAIN: begin
                busy_o = 1'b1;
                if (r_drain == '0)
                    w_next = S_DONE;
            end
            S_DONE: begin
                busy_o = 1'b1;
                done_o = 1'b1;
                w_next = S_IDLE;
            end
        endcase
    end

    // Drain holds D-1 on entry so DONE lands one cycle after the deepest lane.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
            r_beats <= '0;
            r_drain <= '0;
        end else begin
            r_state <= w_next;
            if (w_start_acc)
                r_beats <= w_k_clamp;
            else if (w_accept)
                r_beats <= r_beats - KW'(1);
            if (r_state == S_STREAM)
                r_drain <= DW'(D - 1);
            else if (r_state == S_DRAIN && r_drain != '0)
                r_drain <= r_drain - DW'(1);
        end
    end

`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0] r_bubbles;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            r_bubbles <= '0;
        else if (w_start_acc)
            r_bubbles <= '0;
        else if (r_state == S_STREAM && !in_valid_i && r_bubbles != 16'hFFFF)
            r_bubbles <= r_bubbles + 16'd1;
    end

    assign bubble_cnt_o = r_bubbles;
`endif

    for (genvar r = 0; r < ROWS; r++) begin : g_west
        logic [NUM_BITS-1:0] r_d [r+1];
        logic [r:0]          r_v;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s <= r; s++)
                    r_d[s] <= '0;
                r_v <= '0;
            end else begin
                r_d[0] <= w_accept ? a_i[r] : '0;
                r_v[0] <= w_accept;
                for (int s = 1; s <= r; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end

        assign left_o[r]       = r_d[r];
        assign left_valid_o[r] = r_v[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_north
        logic [NUM_BITS-1:0] r_d [c+1];
        logic [c:0]          r_v;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                for (int s = 0; s <= c; s++)
                    r_d[s] <= '0;
                r_v <= '0;
            end else begin
                r_d[0] <= w_accept ? b_i[c] : '0;
                r_v[0] <= w_accept;
                for (int s = 1; s <= c; s++) begin
                    r_d[s] <= r_d[s-1];
                    r_v[s] <= r_v[s-1];
                end
            end
        end

        assign top_o[c]       = r_d[c];
        assign top_valid_o[c] = r_v[c];
    end

endmodule

// File: tb/tb_edge_skew_feeder.sv
// Scoreboard bench for edge_skew_feeder: a 4x4 instance and a 2x6 instance.
// Define FEEDER_BUBBLE_CNT_EN to also check the bubble counter.
module tb_edge_skew_feeder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic             st0, iv0, busy0, done0, rdy0;
    logic [4:0]       k0;
    logic [3:0][7:0]  a0, b0, left0, top0;
    logic [3:0]       lv0, tv0;
    logic             st1, iv1, busy1, done1, rdy1;
    logic [4:0]       k1;
    logic [1:0][7:0]  a1, left1;
    logic [5:0][7:0]  b1, top1;
    logic [1:0]       lv1;
    logic [5:0]       tv1;
`ifdef FEEDER_BUBBLE_CNT_EN
    logic [15:0]      bc0, bc1;
`endif

    edge_skew_feeder #(.ROWS(4), .COLS(4), .NUM_BITS(8), .K_MAX(16)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st0), .k_i(k0),
        .busy_o(busy0), .done_o(done0), .in_valid_i(iv0), .in_ready_o(rdy0),
        .a_i(a0), .b_i(b0), .left_o(left0), .left_valid_o(lv0),
        .top_o(top0), .top_valid_o(tv0)
`ifdef FEEDER_BUBBLE_CNT_EN
        , .bubble_cnt_o(bc0)
`endif
    );

    edge_skew_feeder #(.ROWS(2), .COLS(6), .NUM_BITS(8), .K_MAX(16)) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n), .start_i(st1), .k_i(k1),
        .busy_o(busy1), .done_o(done1), .in_valid_i(iv1), .in_ready_o(rdy1),
        .a_i(a1), .b_i(b1), .left_o(left1), .left_valid_o(lv1),
        .top_o(top1), .top_valid_o(tv1)
`ifdef FEEDER_BUBBLE_CNT_EN
        , .bubble_cnt_o(bc1)
`endif
    );

    typedef struct {
        int c;
        int v;
    } exp_t;

    // side 0/1: dut0 west/north, side 2/3: dut1 west/north
    exp_t q [4][6][$];
    int   qd [2][$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic lane(input int s, input int l, input logic v,
                        input logic [7:0] d);
        exp_t e;
        if (v) begin
            if (q[s][l].size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL lane%0d.%0d: unexpected valid data %0d, expected idle (cycle %0d)",
                         s, l, d, cyc);
            end else begin
                e = q[s][l].pop_front();
                chk($sformatf("lane%0d.%0d cycle", s, l), cyc, e.c);
                chk($sformatf("lane%0d.%0d data", s, l), d, e.v);
            end
        end else if (d != 8'd0) begin
            n_cmp++;
            n_err++;
            $display("FAIL lane%0d.%0d: invalid data %0d, expected 0 (cycle %0d)",
                     s, l, d, cyc);
        end
    endtask

    task automatic dn(input int d);
        if (qd[d].size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL done%0d: unexpected pulse got 1, expected 0 (cycle %0d)",
                     d, cyc);
        end else begin
            chk($sformatf("done%0d cycle", d), cyc, qd[d].pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int r = 0; r < 4; r++) lane(0, r, lv0[r], left0[r]);
            for (int c = 0; c < 4; c++) lane(1, c, tv0[c], top0[c]);
            for (int r = 0; r < 2; r++) lane(2, r, lv1[r], left1[r]);
            for (int c = 0; c < 6; c++) lane(3, c, tv1[c], top1[c]);
            if (done0) dn(0);
            if (done1) dn(1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input int d, input int k);
        if (d == 0) begin st0 = 1'b1; k0 = 5'(k); end
        else        begin st1 = 1'b1; k1 = 5'(k); end
        tick();
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    task automatic beat(input int d, input logic v,
                        input logic [5:0][7:0] av, input logic [5:0][7:0] bv);
        int nl, nt;
        nl = (d == 0) ? 4 : 2;
        nt = (d == 0) ? 4 : 6;
        if (d == 0) begin
            a0 = av[3:0]; b0 = bv[3:0]; iv0 = v;
            chk("ready0 in stream", rdy0, 1);
        end else begin
            a1 = av[1:0]; b1 = bv; iv1 = v;
            chk("ready1 in stream", rdy1, 1);
        end
        if (v) begin
            for (int r = 0; r < nl; r++)
                q[2*d][r].push_back('{cyc + 1 + r, int'(av[r])});
            for (int c = 0; c < nt; c++)
                q[2*d+1][c].push_back('{cyc + 1 + c, int'(bv[c])});
        end
        tick();
        iv0 = 1'b0;
        iv1 = 1'b0;
    endtask

    function automatic int pending(input int d);
        int n;
        n = qd[d].size();
        for (int s = 2*d; s < 2*d + 2; s++)
            for (int l = 0; l < 6; l++)
                n += q[s][l].size();
        return n;
    endfunction

    task automatic idle(input int d);
        for (int i = 0; i < 60 && ((d == 0) ? busy0 : busy1); i++)
            tick();
        chk($sformatf("busy%0d timeout", d), (d == 0) ? busy0 : busy1, 0);
        repeat (10) tick();
        chk($sformatf("pending%0d", d), pending(d), 0);
    endtask

    logic [5:0][7:0] av, bv;
    int t;

    task automatic scen1();
        start(0, 1);
        t = cyc;
        av = '0; bv = '0;
        av[0] = 8'd1; av[1] = 8'd2; av[2] = 8'd3; av[3] = 8'd4;
        bv[0] = 8'd5; bv[1] = 8'd6; bv[2] = 8'd7; bv[3] = 8'd8;
        qd[0].push_back(t + 5);
        beat(0, 1'b1, av, bv);
        repeat (4) tick();
        chk("s1 busy at done", busy0, 1);
        tick();
        chk("s1 busy after done", busy0, 0);
        idle(0);
    endtask

    initial begin
        st0 = 0; iv0 = 0; k0 = '0; a0 = '0; b0 = '0;
        st1 = 0; iv1 = 0; k1 = '0; a1 = '0; b1 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst busy0", busy0, 0);
        chk("rst done0", done0, 0);
        chk("rst ready0", rdy0, 0);
        chk("rst left0", left0, 0);
        chk("rst lvalid0", lv0, 0);
        chk("rst top0", top0, 0);
        chk("rst tvalid0", tv0, 0);
        chk("rst top1", top1, 0);
`ifdef FEEDER_BUBBLE_CNT_EN
        chk("rst bubble0", bc0, 0);
`endif
        rst_n = 1'b1;
        tick();

        scen1();

        // three back-to-back beats
        start(0, 3);
        t = cyc;
        qd[0].push_back(t + 7);
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 6; i++) begin
                av[i] = 8'(10 * k + i);
                bv[i] = 8'(10 * k + i + 50);
            end
            beat(0, 1'b1, av, bv);
        end
        chk("s2 ready after last", rdy0, 0);
        idle(0);

        // two bubbles between beats; bubble data must not leak
        start(0, 2);
        t = cyc;
        qd[0].push_back(t + 8);
        for (int i = 0; i < 6; i++) begin
            av[i] = 8'(100 + i);
            bv[i] = 8'(120 + i);
        end
        beat(0, 1'b1, av, bv);
        av = {6{8'hAA}}; bv = {6{8'h55}};
        beat(0, 1'b0, av, bv);
        beat(0, 1'b0, av, bv);
        for (int i = 0; i < 6; i++) begin
            av[i] = 8'(200 + i);
            bv[i] = 8'(220 + i);
        end
        beat(0, 1'b1, av, bv);
        idle(0);
`ifdef FEEDER_BUBBLE_CNT_EN
        chk("s3 bubble count", bc0, 2);
`endif

        // empty tile
        qd[0].push_back(cyc + 1);
        start(0, 0);
        chk("s4 ready in done", rdy0, 0);
        chk("s4 done pulse", done0, 1);
        idle(0);

        // 2x6 array, with an ignored start while busy
        start(1, 1);
        t = cyc;
        qd[1].push_back(t + 7);
        for (int i = 0; i < 6; i++) begin
            av[i] = 8'(30 + i);
            bv[i] = 8'(40 + i);
        end
        beat(1, 1'b1, av, bv);
        tick();
        tick();
        st1 = 1'b1;
        k1 = 5'd1;
        tick();
        st1 = 1'b0;
        idle(1);

        // reset in the middle of drain
        start(0, 1);
        for (int i = 0; i < 6; i++) begin
            av[i] = 8'(60 + i);
            bv[i] = 8'(70 + i);
        end
        beat(0, 1'b1, av, bv);
        for (int l = 1; l < 4; l++) begin
            q[0][l].delete();
            q[1][l].delete();
        end
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid rst busy0", busy0, 0);
        chk("mid rst done0", done0, 0);
        chk("mid rst left0", left0, 0);
        chk("mid rst lvalid0", lv0, 0);
        chk("mid rst top0", top0, 0);
        chk("mid rst tvalid0", tv0, 0);
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        chk("post rst pending", pending(0), 0);

        scen1();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/edge_skew_feeder.md
# edge_skew_feeder

Streams operand tiles into the west and north edges of the ROWS x COLS PE array with the diagonal skew that systolic timing requires. Each accepted beat carries one A column slice (one element per row) and one B row slice (one element per column). Lane r / c is delayed by r / c cycles. Idle lanes carry zero with valid low, so PEs accumulate nothing. The block sits between the operand buffers and the array, next to the controller, and replaces the undriven left and top edge wires.

## Interface
Parameters:
- ROWS, 4, PE rows; number of west lanes (>=1)
- COLS, 4, PE columns; number of north lanes (>=1)
- NUM_BITS, 8, operand width
- K_MAX, 16, max beats per tile; KW = $clog2(K_MAX+1)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset; one clock, reset asynchronous and active-low
- start_i  in  1  begin tile; sampled only in IDLE
- k_i  in  KW  beats in tile, 0..K_MAX; sampled with start_i
- busy_o  out  1  high from cycle after accepted start through done cycle
- done_o  out  1  one-cycle pulse, tile fully emitted
- in_valid_i  in  1  beat valid
- in_ready_o  out  1  high only in STREAM
- a_i  in  ROWS x NUM_BITS  A column slice
- b_i  in  COLS x NUM_BITS  B row slice
- left_o  out  ROWS x NUM_BITS  west edge data, lane r feeds PE[r][0]
- left_valid_o  out  ROWS  west lane valid
- top_o  out  COLS x NUM_BITS  north edge data, lane c feeds PE[0][c]
- top_valid_o  out  COLS  north lane valid
- bubble_cnt_o  out  16  only with FEEDER_BUBBLE_CNT_EN

## Operation
- States: IDLE, STREAM, DRAIN, DONE.
- IDLE: if start_i and k_i>0, latch k_i into beat counter and go to STREAM. If start_i and k_i==0, go to DONE. start_i in any other state is ignored.
- STREAM: in_ready_o=1. A beat is accepted when in_valid_i & in_ready_o; it decrements the beat counter. Accepting the last beat goes to DRAIN.
- Bubble: in STREAM with in_valid_i=0, a zero beat with valid 0 enters all lanes at once. Skew alignment is preserved.
- DRAIN: in_ready_o=0. Wait until the last beat has left the deepest lane, then go to DONE.
- DONE: done_o=1 for one cycle, then IDLE.
- Skew: lane r is an r+1-stage register chain (data + valid). Stage 0 is loaded from a_i[r] on accept, else zero/0. The same holds for north lanes with b_i[c].
- Data on non-valid lane cycles is forced to zero.
- D = max(ROWS, COLS). Beat counter saturates at K_MAX; k_i > K_MAX is clamped to K_MAX.
- Reset (asynchronous, any state): state IDLE, all skew stages zero/invalid, counters zero. Reset mid-operation discards the tile with no done_o.

## Timing
- Reset values: busy_o=0, done_o=0, in_ready_o=0, left_o/top_o=0, left_valid_o/top_valid_o=0, bubble_cnt_o=0.
- in_ready_o rises the cycle after start_i is sampled.
- Beat accepted in cycle t: left_o[r]=a_i[r] with valid in cycle t+1+r; top_o[c]=b_i[c] with valid in cycle t+1+c.
- Last beat accepted in cycle T: last edge output in cycle T+D; done_o in cycle T+D+1; busy_o low from T+D+2.
- k_i==0 at start in cycle s: done_o in s+1, no lane goes valid, in_ready_o stays 0.
- Back-to-back tiles: earliest next start_i is sampled in the cycle after done_o (IDLE).

## Configuration
- FEEDER_BUBBLE_CNT_EN defined: bubble_cnt_o present. It counts STREAM cycles with in_valid_i=0, saturates at 16'hFFFF, and clears on accepted start_i and on reset.
- Not defined: port and counter absent; all other behaviour identical.

## Test plan
- ROWS=COLS=4, k=1, a={1,2,3,4}, b={5,6,7,8} accepted cycle 0 -> left_o[0]=1 @1, left_o[3]=4 @4, top_o[2]=7 @3, each valid exactly one cycle; done_o @5.
- k=3, beats accepted cycles 0,1,2, a[r]=10*beat+r -> lane r carries 10r', consecutive valid values from cycle 1+r; done_o @7; in_ready_o low from cycle 3.
- k=2, in_valid_i low in cycles 1-2, second beat accepted cycle 3 -> each lane shows beat0, two zero/invalid cycles, then beat1; done_o @8; bubble_cnt_o=2 when FEEDER_BUBBLE_CNT_EN is defined.
- start_i with k_i=0 -> done_o next cycle, no valid on any lane, in_ready_o never 1.
- ROWS=2, COLS=6, k=1 accepted cycle 0 -> left_o[1] valid @2, top_o[5] valid @6, done_o @7. start_i pulsed @3 (busy) -> ignored, no second done_o.
- rst_ni asserted mid-DRAIN -> all outputs zero/invalid immediately, busy_o=0, no done_o. A new tile after reset release behaves per the first scenario.
